// File: rtl/muldiv_seq_pkg.sv
// Shared opcode/state encodings and defaults for the HI/LO multiply/divide sequencer.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WRITE
  } state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  localparam int TIMEOUT_DEF = 40;

endpackage

// File: rtl/muldiv_seq.sv
// Sequencer between the control unit and the external multiply/divide engines; owns HI/LO.
// All pulse outputs are registered: starts leave with the LAUNCH edge, done leaves with the WRITE/timeout edge.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        mul_start,
  output logic        div_start,
  output logic [31:0] eng_x,
  output logic [31:0] eng_y,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout_err,
  output logic        eng_abort
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;

  state_e        state, state_nxt;
  op_e           op_q;
  logic          dz_q;
  logic [CW-1:0] wait_cnt;
  hilo_t         res;
  logic          eng_hit, timeout_hit, needs_eng;

  always_comb begin
    eng_hit     = (op_q == OP_MULT) ? mul_done : div_done;
    timeout_hit = !eng_hit && (wait_cnt == CW'(TIMEOUT - 1));
    // MULT, and DIV with a nonzero divisor, go through an engine; everything else writes directly
    needs_eng   = !op_code[1] && !((op_e'(op_code) == OP_DIV) && (rt_val == '0));
  end

  assign op_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (op_valid) state_nxt = needs_eng ? S_LAUNCH : S_WRITE;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_hit)          state_nxt = S_WRITE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_WRITE:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_MULT;
      dz_q        <= 1'b0;
      eng_x       <= '0;
      eng_y       <= '0;
      res         <= '0;
      hi          <= '0;
      lo          <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      mul_start   <= 1'b0;
      div_start   <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      eng_abort   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      eng_abort <= 1'b0;
      unique case (state)
        S_IDLE: if (op_valid) begin
          op_q  <= op_e'(op_code);
          dz_q  <= (op_e'(op_code) == OP_DIV) && (rt_val == '0);
          eng_x <= rs_val;
          eng_y <= rt_val;
        end
        S_LAUNCH: begin
          mul_start <= (op_q == OP_MULT);
          div_start <= (op_q == OP_DIV);
          wait_cnt  <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (eng_hit) begin
            res.hi <= (op_q == OP_MULT) ? mul_hi : div_hi;
            res.lo <= (op_q == OP_MULT) ? mul_lo : div_lo;
          end else if (timeout_hit) begin
            // abandon the engine; HI/LO keep their old values
            timeout_err <= 1'b1;
            eng_abort   <= 1'b1;
            done        <= 1'b1;
          end
        end
        S_WRITE: begin
          done     <= 1'b1;
          div_zero <= dz_q;
          unique case (op_q)
            OP_MTHI: hi <= eng_x;
            OP_MTLO: lo <= eng_x;
            default: if (!dz_q) begin
              hi <= res.hi;
              lo <= res.lo;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected starts/completions, a monitor pops and compares.
// Timing reference: accept = the clock edge that latches the op; engine done = the cycle the pulse is driven.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [1:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        mul_start, div_start;
  logic [31:0] eng_x, eng_y;
  logic        mul_done, div_done;
  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, timeout_err, eng_abort;

  muldiv_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .mul_start(mul_start), .div_start(div_start),
    .eng_x(eng_x), .eng_y(eng_y), .mul_done(mul_done), .div_done(div_done),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .timeout_err(timeout_err), .eng_abort(eng_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] hi, lo, x, y;
    bit          dz, to, te, xy;
  } done_t;

  typedef struct {
    int          cyc;
    bit          is_mul;
    logic [31:0] x, y;
  } start_t;

  done_t       sb_done[$];
  start_t      sb_start[$];
  int          n_chk = 0, n_fail = 0;
  int          idle_chk_cyc = -1;
  bit          end_req = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          m_te = 1'b0;

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    done_t  e;
    start_t st;
    forever begin
      @(negedge clk);
      if (end_req) begin
        chk("start_queue_drained", 64'(sb_start.size()), 64'd0);
        chk("done_queue_drained", 64'(sb_done.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      if (!reset) begin
        if (mul_start || div_start) begin
          if (sb_start.size() == 0) chk("spurious_start", {mul_start, div_start}, 64'd0);
          else begin
            st = sb_start.pop_front();
            chk("start_cycle", 64'(cyc), 64'(st.cyc));
            chk("start_kind", {mul_start, div_start}, st.is_mul ? 64'd2 : 64'd1);
            chk("start_eng_x", eng_x, st.x);
            chk("start_eng_y", eng_y, st.y);
          end
        end else if (sb_start.size() != 0 && cyc > sb_start[0].cyc) begin
          st = sb_start.pop_front();
          chk("start_missing_at", 64'(cyc), 64'(st.cyc));
        end

        if (done) begin
          if (sb_done.size() == 0) chk("spurious_done", 64'(done), 64'd0);
          else begin
            e = sb_done.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("done_hi", hi, e.hi);
            chk("done_lo", lo, e.lo);
            chk("done_div_zero", 64'(div_zero), 64'(e.dz));
            chk("done_eng_abort", 64'(eng_abort), 64'(e.to));
            chk("done_timeout_err", 64'(timeout_err), 64'(e.te));
            if (e.xy) begin
              chk("done_eng_x_held", eng_x, e.x);
              chk("done_eng_y_held", eng_y, e.y);
            end
          end
        end else begin
          chk("no_flag_without_done", {div_zero, eng_abort}, 64'd0);
          if (sb_done.size() != 0 && cyc > sb_done[0].cyc) begin
            e = sb_done.pop_front();
            chk("done_missing_at", 64'(cyc), 64'(e.cyc));
          end
        end

        if (cyc == idle_chk_cyc) begin
          chk("idle_op_ready", 64'(op_ready), 64'd1);
          chk("idle_busy", 64'(busy), 64'd0);
          chk("idle_hi", hi, m_hi);
          chk("idle_lo", lo, m_lo);
          chk("idle_timeout_err", 64'(timeout_err), 64'(m_te));
          chk("idle_pulses", {mul_start, div_start, done}, 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic junk_engine();
    mul_hi = $urandom; mul_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, output int acc);
    int w = 0;
    acc = -1;
    op_valid = 1'b1; op_code = op; rs_val = rs; rt_val = rt;
    while (w < 200) begin
      @(negedge clk);
      if (op_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      w++;
    end
    op_valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
    if (acc < 0) begin
      $display("FAIL accept_timeout: op_ready never rose, cycle %0d", cyc);
      $fatal(1, "accept timeout");
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int delay, input bit respond, input bit stray);
    int a, si, ti;
    longint p;
    logic [31:0] rh, rl;
    done_t e;
    start_t st;
    issue(op, rs, rt, a);
    e.te = m_te; e.dz = 1'b0; e.to = 1'b0; e.xy = 1'b0; e.x = rs; e.y = rt;
    if (op[1] || (op == OP_DIV && rt == '0)) begin
      if (op == OP_MTHI) m_hi = rs;
      else if (op == OP_MTLO) m_lo = rs;
      else e.dz = 1'b1;
      e.cyc = a + 1; e.hi = m_hi; e.lo = m_lo;
      sb_done.push_back(e);
      return;
    end
    st.cyc = a + 1; st.is_mul = (op == OP_MULT); st.x = rs; st.y = rt;
    sb_start.push_back(st);
    if (!respond) begin
      m_te = 1'b1;
      e.te = 1'b1; e.to = 1'b1; e.cyc = a + 1 + TO; e.hi = m_hi; e.lo = m_lo;
      sb_done.push_back(e);
      return;
    end
    si = int'(rs); ti = int'(rt);
    if (op == OP_MULT) begin
      p = longint'(si) * longint'(ti);
      rh = p[63:32]; rl = p[31:0];
    end else begin
      rh = 32'(si % ti); rl = 32'(si / ti);
    end
    for (int i = 1; i <= delay + 1; i++) begin
      @(posedge clk); #1;
      mul_done = 1'b0; div_done = 1'b0; junk_engine();
      if (i == 1) begin
        op_valid = 1'b1; op_code = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      end
      if (stray && i == 2 && delay >= 2) begin
        if (op == OP_MULT) div_done = 1'b1; else mul_done = 1'b1;
      end
      if (i == delay + 1) begin
        op_valid = 1'b0;
        if (op == OP_MULT) begin mul_done = 1'b1; mul_hi = rh; mul_lo = rl; end
        else begin div_done = 1'b1; div_hi = rh; div_lo = rl; end
        m_hi = rh; m_lo = rl;
        e.cyc = cyc + 2; e.hi = rh; e.lo = rl; e.xy = 1'b1;
        sb_done.push_back(e);
      end
    end
    @(posedge clk); #1;
    mul_done = 1'b0; div_done = 1'b0; junk_engine();
  endtask

  task automatic wait_idle_check();
    int w = 0;
    while (!op_ready && w < 200) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    idle_chk_cyc = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    int a;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    reset = 1'b1; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0;
    mul_done = 1'b0; div_done = 1'b0; mul_hi = '0; mul_lo = '0; div_hi = '0; div_lo = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_chk_cyc = cyc;
    @(posedge clk); #1;

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 33, 1'b1, 1'b0);
    run_op(OP_DIV, 32'd100, 32'd0, 0, 1'b1, 1'b0);
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, 1'b0);
    run_op(OP_MTLO, 32'h1234_5678, 32'h0, 0, 1'b1, 1'b0);
    wait_idle_check();
    run_op(OP_DIV, 32'd100, 32'd3, 10, 1'b1, 1'b1);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, TO - 1, 1'b1, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1, 1'b1, 1'b0);
    run_op(OP_MULT, 32'd5, 32'd5, 0, 1'b0, 1'b0);
    run_op(OP_MTLO, 32'hCAFE_0001, 32'h0, 0, 1'b1, 1'b0);

    // engine pulses while idle must be ignored
    wait_idle_check();
    mul_done = 1'b1; div_done = 1'b1; junk_engine();
    @(posedge clk); #1;
    mul_done = 1'b0; div_done = 1'b0;
    idle_chk_cyc = cyc;
    @(posedge clk); #1;

    for (int k = 0; k < 20; k++) begin
      op = 2'($urandom_range(0, 3));
      rs = $urandom; rt = $urandom;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) rt = '0;
      if (rt == 32'hFFFF_FFFF) rt = 32'd3;
      run_op(op, rs, rt, $urandom_range(1, TO - 1), 1'b1, 1'($urandom_range(0, 1)));
    end
    wait_idle_check();

    // reset in the middle of WAIT, then a late engine done
    issue(OP_DIV, 32'd100, 32'd3, a);
    st_push: begin
      start_t st;
      st.cyc = a + 1; st.is_mul = 1'b0; st.x = 32'd100; st.y = 32'd3;
      sb_start.push_back(st);
    end
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_te = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_chk_cyc = cyc;
    div_done = 1'b1; div_hi = 32'd1; div_lo = 32'd33;
    @(posedge clk); #1;
    div_done = 1'b0;
    idle_chk_cyc = cyc;
    repeat (4) begin @(posedge clk); #1; end
    end_req = 1'b1;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum cycles to wait for engine completion.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  control unit presents an operation.
REQ-005 op_ready  out  1  sequencer can accept an operation (high only in IDLE).
REQ-006 op_code  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-007 rs_val, rt_val  in  32 each  operands; MTHI/MTLO use rs_val.
REQ-008 mul_start, div_start  out  1 each  one-cycle launch pulses to the multiplier / divider.
REQ-009 eng_x, eng_y  out  32 each  operands to engines, held stable from launch until completion.
REQ-010 mul_done, div_done  in  1 each  engine completion pulses.
REQ-011 mul_hi, mul_lo, div_hi, div_lo  in  32 each  engine results, valid in the cycle of the matching done pulse.
REQ-012 hi, lo  out  32 each  architectural HI/LO registers.
REQ-013 busy  out  1  high in any state other than IDLE; control unit stalls MFHI/MFLO while high.
REQ-014 done  out  1  one-cycle pulse at operation completion, including error completions.
REQ-015 div_zero  out  1  pulse coincident with done when DIV had rt_val == 0.
REQ-016 timeout_err  out  1  sticky flag; cleared only by reset.
REQ-017 eng_abort  out  1  one-cycle pulse after a timeout; engines return to idle on it.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT, WRITE; sequencer holds at most one operation.
REQ-019 Accept: op_valid && op_ready in IDLE latches op_code, rs_val→eng_x and rt_val→eng_y.
REQ-020 MULT/DIV accept: IDLE→LAUNCH; in LAUNCH the matching start pulses exactly one cycle, then →WAIT.
REQ-021 DIV with rt_val == 0: no div_start; IDLE→WRITE, hi/lo unchanged, done and div_zero asserted in WRITE.
REQ-022 MTHI/MTLO: IDLE→WRITE, rs_val written to hi (MTHI) or lo (MTLO) at the WRITE edge, other register unchanged.
REQ-023 WAIT: only the done of the launched engine counts; the other engine's done is ignored.
REQ-024 WAIT with matching done: capture engine hi/lo into internal result regs, →WRITE.
REQ-025 WRITE: result regs copied to hi/lo, done pulses, →IDLE; op_ready high the following cycle.
REQ-026 Latency MULT/DIV: done asserts 2 cycles after engine done; engine launched 1 cycle after accept.
REQ-027 Latency MTHI/MTLO and DIV-by-zero: done asserts 1 cycle after accept.
REQ-028 Wait counter, 6 bits minimum, clears on entering WAIT and increments each WAIT cycle.
REQ-029 Counter reaching TIMEOUT with no done: set timeout_err, pulse eng_abort, pulse done, hi/lo unchanged, →IDLE.
REQ-030 done arriving in the same cycle the counter reaches TIMEOUT: completion wins, no error.
REQ-031 Engine done pulses in IDLE, LAUNCH or WRITE are ignored, with no state change.
REQ-032 op_valid outside IDLE is ignored, with no latch; the control unit holds it until op_ready.
REQ-033 hi and lo change only at the WRITE edge or reset.

Reset
REQ-034 reset has priority over every other input, including an in-flight operation.
REQ-035 Reset values: state IDLE; hi, lo, eng_x, eng_y and result regs 0; timeout_err 0; counter 0.
REQ-036 Reset values: mul_start, div_start, done, div_zero and eng_abort 0; op_ready 1 the cycle after reset releases; busy 0.
REQ-037 Reset during WAIT: the engine result is discarded; engines see the shared reset.

Structure
REQ-038 Shared package holds the op_code enum (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO), the state enum and the TIMEOUT default.
REQ-039 Single module, no sub-modules; the wait counter stays inline.

Verification
REQ-040 MULT rs=7, rt=-3, engine done 33 cycles after start with hi=FFFFFFFF, lo=FFFFFFEB -> hi/lo updated, done exactly 2 cycles after engine done.
REQ-041 DIV rs=100, rt=0 -> no div_start; done and div_zero pulse 1 cycle after accept; hi/lo unchanged.
REQ-042 MTHI rs=0xDEADBEEF then MTLO rs=0x12345678 -> hi=DEADBEEF, lo=12345678, each done 1 cycle after accept.
REQ-043 MULT, engine never responds -> done, eng_abort and timeout_err after 40 WAIT cycles; hi/lo unchanged; a subsequent MTLO succeeds.
REQ-044 DIV launched, stray mul_done in WAIT, then div_done with hi=1, lo=33 (100/3) -> mul_done ignored; hi=1, lo=33.
REQ-045 reset asserted mid-WAIT, then late div_done -> IDLE, hi=lo=0, no done pulse, op_ready high.
